// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - N-channel synchroniser, debounce filter and edge pulse generator
// Optional COND_TOGGLE_EN adds a per-channel push-on/push-off toggle_out.
module input_conditioner #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic            CLK100MHZ,
    input  logic            CPU_RESETN,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] rise_out,
    output logic [N_CH-1:0] fall_out
`ifdef COND_TOGGLE_EN
    ,
    output logic [N_CH-1:0] toggle_out
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_CH-1:0]  s1;
    logic [N_CH-1:0]  s2;
    logic [N_CH-1:0]  accept;
    logic [CNT_W-1:0] cnt [N_CH];

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw_in;
            s2 <= s1;
        end
    end

    // A channel flips once s2 has disagreed with the level for DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        accept = '0;
        for (int i = 0; i < N_CH; i++) begin
            accept[i] = (s2[i] != level_out[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if ((s2[i] == level_out[i]) || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            level_out <= '0;
            rise_out  <= '0;
            fall_out  <= '0;
        end else begin
            level_out <= level_out ^ accept;
            rise_out  <= accept & s2;
            fall_out  <= accept & ~s2;
        end
    end

`ifdef COND_TOGGLE_EN
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            toggle_out <= '0;
        end else begin
            toggle_out <= toggle_out ^ rise_out;
        end
    end
`endif

endmodule
